// File: rtl/cpu_led_blink_pio.sv
// -----------------------------------------------------------------------------
// cpu_led_blink_pio
//   Avalon-MM output PIO for the status LEDs. It provides DATA_WIDTH output
//   bits with atomic set/clear/toggle writes. A shared blink timer can flash
//   any subset of bits without CPU polling.
//   It is a zero-wait-state slave: writes take effect on the clock edge of the
//   write, and reads are combinational.
//
// Ports
//   clk         system clock, all state on its rising edge
//   reset_n     asynchronous active-low reset
//   address     register word address (0..7)
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   write data; bits above the register width are ignored
//   readdata    combinational read data, zero-extended
//   out_port    LED drive
//
// Register map
//   0 DATA  1 BLINKEN  2 PERIOD  3 OUTSET  4 OUTCLEAR  5 TOGGLE  6,7 unused
// -----------------------------------------------------------------------------
module cpu_led_blink_pio #(
    parameter int unsigned              DATA_WIDTH   = 8,
    parameter int unsigned              CNT_WIDTH    = 24,
    parameter logic [DATA_WIDTH-1:0]    RESET_VALUE  = '0,
    parameter logic [CNT_WIDTH-1:0]     RESET_PERIOD = '0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [2:0]              address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    output logic [DATA_WIDTH-1:0]   out_port
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_BLINKEN  = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_OUTSET   = 3'd3;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd4;
    localparam logic [2:0] ADDR_TOGGLE   = 3'd5;

    logic                   wr;
    logic [DATA_WIDTH-1:0]  wd_data;
    logic [CNT_WIDTH-1:0]   wd_period;
    logic                   unused_wd;

    logic [DATA_WIDTH-1:0]  data_q,     data_d;
    logic [DATA_WIDTH-1:0]  blink_en_q, blink_en_d;
    logic [CNT_WIDTH-1:0]   period_q,   period_d;
    logic [CNT_WIDTH-1:0]   cnt_q,      cnt_d;
    logic                   phase_q,    phase_d;

    assign wr        = chipselect & ~write_n;
    assign wd_data   = writedata[DATA_WIDTH-1:0];
    assign wd_period = writedata[CNT_WIDTH-1:0];
    // Upper writedata bits are intentionally discarded.
    assign unused_wd = ^writedata;

    // Register writes. The set/clear/toggle ops are all relative to the
    // current DATA value, so the CPU never needs a read-modify-write.
    always_comb begin
        data_d     = data_q;
        blink_en_d = blink_en_q;
        period_d   = period_q;
        if (wr) begin
            case (address)
                ADDR_DATA:     data_d     = wd_data;
                ADDR_BLINKEN:  blink_en_d = wd_data;
                ADDR_PERIOD:   period_d   = wd_period;
                ADDR_OUTSET:   data_d     = data_q | wd_data;
                ADDR_OUTCLEAR: data_d     = data_q & ~wd_data;
                ADDR_TOGGLE:   data_d     = data_q ^ wd_data;
                default:       ;
            endcase
        end
    end

    // Blink timer. A PERIOD write restarts the timer and takes priority over
    // a wrap in the same cycle. The restart also keeps cnt from being
    // stranded above a newly shrunk period.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (wr && (address == ADDR_PERIOD)) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (period_q == '0) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == period_q - CNT_WIDTH'(1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= RESET_VALUE;
            blink_en_q <= '0;
            period_q   <= RESET_PERIOD;
            cnt_q      <= '0;
            phase_q    <= 1'b0;
        end else begin
            data_q     <= data_d;
            blink_en_q <= blink_en_d;
            period_q   <= period_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
        end
    end

    // A blinking bit is lit during phase 0 and dark during phase 1. It is
    // still gated by its DATA bit.
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_out
        assign out_port[gi] = data_q[gi] & ~(blink_en_q[gi] & phase_q);
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata[DATA_WIDTH-1:0] = data_q;
            ADDR_BLINKEN: readdata[DATA_WIDTH-1:0] = blink_en_q;
            ADDR_PERIOD:  readdata[CNT_WIDTH-1:0]  = period_q;
            ADDR_OUTSET:  readdata[DATA_WIDTH-1:0] = out_port;
            ADDR_TOGGLE:  readdata[0]              = phase_q;
            default:      readdata                 = '0;
        endcase
    end

endmodule

// File: tb/tb_cpu_led_blink_pio.sv
`timescale 1ns/1ps
module tb_cpu_led_blink_pio;

    localparam int          DW    = 8;
    localparam int          CW    = 24;
    localparam logic [7:0]  RV    = 8'hA5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [DW-1:0] out_port;

    int n_cmp = 0;
    int n_bad = 0;

    cpu_led_blink_pio #(
        .DATA_WIDTH   (DW),
        .CNT_WIDTH    (CW),
        .RESET_VALUE  (RV),
        .RESET_PERIOD (24'd0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    // Behavioural model. The blink phase is derived arithmetically from the
    // number of clocks elapsed since the timer was last restarted.
    logic [DW-1:0] m_data   = RV;
    logic [DW-1:0] m_blink  = '0;
    logic [CW-1:0] m_period = '0;
    longint        m_k      = 0;
    logic          exp_phase;
    logic [DW-1:0] exp_out;
    logic [31:0]   exp_rd;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_data   <= RV;
            m_blink  <= '0;
            m_period <= '0;
            m_k      <= 0;
        end else begin
            if (chipselect && !write_n) begin
                case (address)
                    3'd0: m_data   <= writedata[7:0];
                    3'd1: m_blink  <= writedata[7:0];
                    3'd2: m_period <= writedata[23:0];
                    3'd3: m_data   <= m_data | writedata[7:0];
                    3'd4: m_data   <= m_data & ~writedata[7:0];
                    3'd5: m_data   <= m_data ^ writedata[7:0];
                    default: ;
                endcase
            end
            if (chipselect && !write_n && address == 3'd2) m_k <= 0;
            else if (m_period != 0)                        m_k <= m_k + 1;
        end
    end

    always_comb begin
        exp_phase = 1'b0;
        if (m_period != 0) exp_phase = ((m_k / longint'(m_period)) % 2) == 1;
        exp_out = m_data & ~(m_blink & {DW{exp_phase}});
        exp_rd  = 32'd0;
        case (address)
            3'd0: exp_rd = {24'd0, m_data};
            3'd1: exp_rd = {24'd0, m_blink};
            3'd2: exp_rd = {8'd0, m_period};
            3'd3: exp_rd = {24'd0, exp_out};
            3'd5: exp_rd = {31'd0, exp_phase};
            default: exp_rd = 32'd0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t actual=0x%08h required=0x%08h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from both clock edges.
    always @(negedge clk) begin
        #2;
        check("cyc_out", {24'd0, out_port}, {24'd0, exp_out});
        check("cyc_rd", readdata, exp_rd);
    end

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
        $display("write addr=%0d data=0x%08h", a, d);
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b1; address = a;
        #1;
        $display("read  addr=%0d data=0x%08h", a, readdata);
        check(name, readdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t actual=timeout required=finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        address = 3'd0; writedata = 32'd0;

        // 1 reset values
        repeat (2) @(negedge clk);
        #1 check("rst_out", {24'd0, out_port}, 32'h000000A5);
        rd_chk("rst_data",   3'd0, 32'h000000A5);
        rd_chk("rst_blink",  3'd1, 32'h0);
        rd_chk("rst_period", 3'd2, 32'h0);
        @(negedge clk) reset_n = 1'b1;

        // 2 atomic operations
        wr_reg(3'd0, 32'h0F);
        wr_reg(3'd3, 32'h30);
        wr_reg(3'd4, 32'h01);
        wr_reg(3'd5, 32'h81);
        rd_chk("atomic_data", 3'd0, 32'hBF);
        rd_chk("outset_rd",   3'd3, 32'hBF);
        rd_chk("outclr_rd",   3'd4, 32'h0);

        // 3 blink with period 3
        wr_reg(3'd0, 32'hFF);
        wr_reg(3'd1, 32'h01);
        wr_reg(3'd2, 32'd3);
        for (int i = 0; i < 12; i++) begin
            #1 check("blink3", {24'd0, out_port}, ((i / 3) % 2) ? 32'hFE : 32'hFF);
            @(negedge clk);
        end

        // 4 PERIOD write colliding with a wrap
        begin
            int n = 0;
            while ((m_k % 3) != 2 && n < 10) begin
                @(negedge clk);
                n++;
            end
            check("wrap_wait", (m_k % 3) == 2 ? 32'd1 : 32'd0, 32'd1);
        end
        chipselect = 1'b1; write_n = 1'b0; address = 3'd2; writedata = 32'd5;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
        $display("write addr=2 data=0x00000005 (on wrap)");
        for (int i = 0; i < 11; i++) begin
            #1 check("blink5", {24'd0, out_port}, ((i / 5) % 2) ? 32'hFE : 32'hFF);
            @(negedge clk);
        end
        wr_reg(3'd2, 32'd0);
        for (int i = 0; i < 8; i++) begin
            #1 check("halt", {24'd0, out_port}, 32'hFF);
            @(negedge clk);
        end

        // 5 width and decode
        wr_reg(3'd0, 32'hFFFF_FFFF);
        rd_chk("width", 3'd0, 32'h000000FF);
        wr_reg(3'd6, 32'h0);
        wr_reg(3'd7, 32'h0);
        rd_chk("addr67_data", 3'd0, 32'hFF);
        rd_chk("addr6_rd",    3'd6, 32'h0);
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b0; address = 3'd0; writedata = 32'h0;
        @(negedge clk);
        write_n = 1'b1;
        rd_chk("cs0_data", 3'd0, 32'hFF);

        // 6 async reset mid-blink
        wr_reg(3'd1, 32'h01);
        wr_reg(3'd2, 32'd4);
        repeat (5) @(negedge clk);
        #1 check("pre_rst", {24'd0, out_port}, 32'hFE);
        #2 reset_n = 1'b0;
        #1 check("async_rst", {24'd0, out_port}, 32'hA5);
        #0.5 reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1 check("post_rst", {24'd0, out_port}, 32'hA5);
        end
        rd_chk("post_rst_period", 3'd2, 32'h0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
